// File: rtl/cu_pkg.sv
// Shared constants and the control bundle for the MIPS-subset decoder.
// CU_ILLEGAL_DET_EN adds an illegal-instruction flag to the bundle.
package cu_pkg;

   typedef enum logic [3:0] {
      ALU_ADD = 4'b0000,
      ALU_SUB = 4'b0001,
      ALU_AND = 4'b0010,
      ALU_OR  = 4'b0011,
      ALU_XOR = 4'b0100,
      ALU_SLL = 4'b0101,
      ALU_SRL = 4'b0110,
      ALU_SRA = 4'b0111,
      ALU_LUI = 4'b1000
   } alu_op_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_XORI  = 6'b001110;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   localparam logic [5:0] F_ADD = 6'b100000;
   localparam logic [5:0] F_SUB = 6'b100010;
   localparam logic [5:0] F_AND = 6'b100100;
   localparam logic [5:0] F_OR  = 6'b100101;
   localparam logic [5:0] F_XOR = 6'b100110;
   localparam logic [5:0] F_SLL = 6'b000000;
   localparam logic [5:0] F_SRL = 6'b000010;
   localparam logic [5:0] F_SRA = 6'b000011;
   localparam logic [5:0] F_JR  = 6'b001000;

   typedef struct packed {
      alu_op_t aluctr;
      logic    reg_wr;
      logic    alu_src;
      logic    reg_dst;
      logic    mem_to_reg;
      logic    mem_wr;
      logic    branch_eq;
      logic    branch_ne;
      logic    jump;
      logic    jump_reg;
      logic    link;
      logic    ext_op;
      logic    shift;
`ifdef CU_ILLEGAL_DET_EN
      logic    illegal;
`endif
   } ctrl_t;

   // All-zero bundle doubles as the reset value and the unknown-instruction NOP.
   localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/cu_decode.sv
// Purely combinational op/func to control-bundle decoder.
// CU_ILLEGAL_DET_EN flags encodings that fall into the NOP default.
module cu_decode
   import cu_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] func,
   output ctrl_t      ctrl
);

   // func is only examined inside the R-type arm, so an undefined func on an
   // I/J-type instruction cannot leak into the strobes; an undefined op matches
   // no case item and lands on the NOP default.
   always_comb begin
      ctrl = CTRL_NOP;
      case (op)
         OP_RTYPE: begin
            ctrl.reg_dst = 1'b1;
            ctrl.reg_wr  = 1'b1;
            case (func)
               F_ADD: ctrl.aluctr = ALU_ADD;
               F_SUB: ctrl.aluctr = ALU_SUB;
               F_AND: ctrl.aluctr = ALU_AND;
               F_OR:  ctrl.aluctr = ALU_OR;
               F_XOR: ctrl.aluctr = ALU_XOR;
               F_SLL: begin ctrl.aluctr = ALU_SLL; ctrl.shift = 1'b1; end
               F_SRL: begin ctrl.aluctr = ALU_SRL; ctrl.shift = 1'b1; end
               F_SRA: begin ctrl.aluctr = ALU_SRA; ctrl.shift = 1'b1; end
               F_JR: begin
                  ctrl.jump     = 1'b1;
                  ctrl.jump_reg = 1'b1;
                  ctrl.reg_wr   = 1'b0;
                  ctrl.reg_dst  = 1'b0;
               end
               default: begin
                  ctrl = CTRL_NOP;
`ifdef CU_ILLEGAL_DET_EN
                  ctrl.illegal = 1'b1;
`endif
               end
            endcase
         end
         OP_ADDI: begin
            ctrl.aluctr  = ALU_ADD;
            ctrl.alu_src = 1'b1;
            ctrl.reg_wr  = 1'b1;
            ctrl.ext_op  = 1'b1;
         end
         OP_ANDI: begin
            ctrl.aluctr  = ALU_AND;
            ctrl.alu_src = 1'b1;
            ctrl.reg_wr  = 1'b1;
         end
         OP_ORI: begin
            ctrl.aluctr  = ALU_OR;
            ctrl.alu_src = 1'b1;
            ctrl.reg_wr  = 1'b1;
         end
         OP_XORI: begin
            ctrl.aluctr  = ALU_XOR;
            ctrl.alu_src = 1'b1;
            ctrl.reg_wr  = 1'b1;
         end
         OP_LW: begin
            ctrl.aluctr     = ALU_ADD;
            ctrl.alu_src    = 1'b1;
            ctrl.reg_wr     = 1'b1;
            ctrl.mem_to_reg = 1'b1;
            ctrl.ext_op     = 1'b1;
         end
         OP_SW: begin
            ctrl.aluctr  = ALU_ADD;
            ctrl.alu_src = 1'b1;
            ctrl.mem_wr  = 1'b1;
            ctrl.ext_op  = 1'b1;
         end
         OP_BEQ: begin
            ctrl.aluctr    = ALU_SUB;
            ctrl.branch_eq = 1'b1;
            ctrl.ext_op    = 1'b1;
         end
         OP_BNE: begin
            ctrl.aluctr    = ALU_SUB;
            ctrl.branch_ne = 1'b1;
            ctrl.ext_op    = 1'b1;
         end
         OP_LUI: begin
            ctrl.aluctr  = ALU_LUI;
            ctrl.alu_src = 1'b1;
            ctrl.reg_wr  = 1'b1;
         end
         OP_J: ctrl.jump = 1'b1;
         OP_JAL: begin
            ctrl.jump   = 1'b1;
            ctrl.link   = 1'b1;
            ctrl.reg_wr = 1'b1;
         end
         default: begin
            ctrl = CTRL_NOP;
`ifdef CU_ILLEGAL_DET_EN
            ctrl.illegal = 1'b1;
`endif
         end
      endcase
   end

endmodule

// File: rtl/mips_control_unit.sv
// Decode stage: combinational cu_decode followed by one register of latency.
// CU_ILLEGAL_DET_EN adds the registered 'illegal' output.
module mips_control_unit
   import cu_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [5:0] op,
   input  logic [5:0] func,
   output logic [3:0] ALUctr,
   output logic       RegWr,
   output logic       ALUSrc,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       MemWr,
   output logic       Branch_eq,
   output logic       Branch_ne,
   output logic       Jump,
   output logic       JumpReg,
   output logic       Link,
   output logic       Extop,
   output logic       Shift
`ifdef CU_ILLEGAL_DET_EN
   ,
   output logic       illegal
`endif
);

   ctrl_t ctrl_next;
   ctrl_t ctrl_q;

   cu_decode u_decode (
      .op   (op),
      .func (func),
      .ctrl (ctrl_next)
   );

   // Reset wins over decode on the same edge so a mid-stream reset yields NOP.
   always_ff @(posedge clk) begin
      if (rst) ctrl_q <= CTRL_NOP;
      else     ctrl_q <= ctrl_next;
   end

   assign ALUctr    = ctrl_q.aluctr;
   assign RegWr     = ctrl_q.reg_wr;
   assign ALUSrc    = ctrl_q.alu_src;
   assign RegDst    = ctrl_q.reg_dst;
   assign MemtoReg  = ctrl_q.mem_to_reg;
   assign MemWr     = ctrl_q.mem_wr;
   assign Branch_eq = ctrl_q.branch_eq;
   assign Branch_ne = ctrl_q.branch_ne;
   assign Jump      = ctrl_q.jump;
   assign JumpReg   = ctrl_q.jump_reg;
   assign Link      = ctrl_q.link;
   assign Extop     = ctrl_q.ext_op;
   assign Shift     = ctrl_q.shift;
`ifdef CU_ILLEGAL_DET_EN
   assign illegal   = ctrl_q.illegal;
`endif

endmodule

// File: tb/tb_mips_control_unit.sv
// Directed self-checking bench for mips_control_unit; expected strobes are hand-written.
// Also checks the illegal output when CU_ILLEGAL_DET_EN is defined.
module tb_mips_control_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic [5:0] op;
   logic [5:0] func;
   logic [3:0] ALUctr;
   logic       RegWr, ALUSrc, RegDst, MemtoReg, MemWr;
   logic       Branch_eq, Branch_ne, Jump, JumpReg, Link, Extop, Shift;
`ifdef CU_ILLEGAL_DET_EN
   logic       illegal;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mips_control_unit dut (
      .clk       (clk),
      .rst       (rst),
      .op        (op),
      .func      (func),
      .ALUctr    (ALUctr),
      .RegWr     (RegWr),
      .ALUSrc    (ALUSrc),
      .RegDst    (RegDst),
      .MemtoReg  (MemtoReg),
      .MemWr     (MemWr),
      .Branch_eq (Branch_eq),
      .Branch_ne (Branch_ne),
      .Jump      (Jump),
      .JumpReg   (JumpReg),
      .Link      (Link),
      .Extop     (Extop),
      .Shift     (Shift)
`ifdef CU_ILLEGAL_DET_EN
      ,
      .illegal   (illegal)
`endif
   );

   // Packs strobes as {ALUctr, RegWr, ALUSrc, RegDst, MemtoReg, MemWr,
   // Branch_eq, Branch_ne, Jump, JumpReg, Link, Extop, Shift}.
   function automatic logic [15:0] mk(input logic [3:0] alu, input logic rw, input logic src,
                                      input logic dst, input logic m2r, input logic mw,
                                      input logic beq, input logic bne, input logic jmp,
                                      input logic jr, input logic lnk, input logic ext,
                                      input logic sh);
      return {alu, rw, src, dst, m2r, mw, beq, bne, jmp, jr, lnk, ext, sh};
   endfunction

   function automatic logic [15:0] observed();
      return {ALUctr, RegWr, ALUSrc, RegDst, MemtoReg, MemWr,
              Branch_eq, Branch_ne, Jump, JumpReg, Link, Extop, Shift};
   endfunction

   task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got=%b expected=%b", tag, got, exp);
      end
   endtask

   task automatic checkIllegal(input string tag, input logic exp_ill);
`ifdef CU_ILLEGAL_DET_EN
      checkOutput({tag, "_illegal"}, {15'd0, illegal}, {15'd0, exp_ill});
`else
      if (exp_ill === 1'bx) $display("[TB] unreachable %s", tag);
`endif
   endtask

   // Drive between edges, then sample 1 time unit after the capturing edge.
   task automatic applyStimulus(input string tag, input logic [5:0] o, input logic [5:0] f,
                                input logic [15:0] exp, input logic exp_ill);
      @(negedge clk);
      op   = o;
      func = f;
      @(posedge clk);
      #1;
      checkOutput(tag, observed(), exp);
      checkIllegal(tag, exp_ill);
   endtask

   localparam logic [15:0] E_NOP  = 16'd0;
   localparam logic [15:0] E_LW   = {4'b0000, 12'b110100000010};
   localparam logic [15:0] E_ADD  = {4'b0000, 12'b101000000000};
   localparam logic [15:0] E_SW   = {4'b0000, 12'b010010000010};

   initial begin
      rst  = 1'b1;
      op   = 6'b100011;
      func = 6'b000000;
      for (int i = 0; i < 2; i++) begin
         @(posedge clk);
         #1;
         checkOutput("reset", observed(), E_NOP);
         checkIllegal("reset", 1'b0);
      end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("lw_after_reset", observed(),
                  mk(4'b0000, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0));

      applyStimulus("r_add", 6'b000000, 6'b100000, mk(4'b0000,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("r_sub", 6'b000000, 6'b100010, mk(4'b0001,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("r_and", 6'b000000, 6'b100100, mk(4'b0010,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("r_or",  6'b000000, 6'b100101, mk(4'b0011,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("r_xor", 6'b000000, 6'b100110, mk(4'b0100,1,0,1,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("r_sll", 6'b000000, 6'b000000, mk(4'b0101,1,0,1,0,0,0,0,0,0,0,0,1), 1'b0);
      applyStimulus("r_srl", 6'b000000, 6'b000010, mk(4'b0110,1,0,1,0,0,0,0,0,0,0,0,1), 1'b0);
      applyStimulus("r_sra", 6'b000000, 6'b000011, mk(4'b0111,1,0,1,0,0,0,0,0,0,0,0,1), 1'b0);
      applyStimulus("r_jr",  6'b000000, 6'b001000, mk(4'b0000,0,0,0,0,0,0,0,1,1,0,0,0), 1'b0);

      applyStimulus("addi", 6'b001000, 6'bxxxxxx, mk(4'b0000,1,1,0,0,0,0,0,0,0,0,1,0), 1'b0);
      applyStimulus("andi", 6'b001100, 6'bxxxxxx, mk(4'b0010,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("ori",  6'b001101, 6'bxxxxxx, mk(4'b0011,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("xori", 6'b001110, 6'bxxxxxx, mk(4'b0100,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("lui",  6'b001111, 6'bxxxxxx, mk(4'b1000,1,1,0,0,0,0,0,0,0,0,0,0), 1'b0);
      applyStimulus("lw",   6'b100011, 6'bxxxxxx, E_LW, 1'b0);
      applyStimulus("sw",   6'b101011, 6'bxxxxxx, E_SW, 1'b0);
      applyStimulus("beq",  6'b000100, 6'bxxxxxx, mk(4'b0001,0,0,0,0,0,1,0,0,0,0,1,0), 1'b0);
      applyStimulus("bne",  6'b000101, 6'bxxxxxx, mk(4'b0001,0,0,0,0,0,0,1,0,0,0,1,0), 1'b0);
      applyStimulus("j",    6'b000010, 6'bxxxxxx, mk(4'b0000,0,0,0,0,0,0,0,1,0,0,0,0), 1'b0);
      applyStimulus("jal",  6'b000011, 6'bxxxxxx, mk(4'b0000,1,0,0,0,0,0,0,1,0,1,0,0), 1'b0);

      applyStimulus("illegal_op",   6'b111111, 6'b100000, E_NOP, 1'b1);
      applyStimulus("illegal_func", 6'b000000, 6'b111111, E_NOP, 1'b1);

      // Inputs changed between edges must not show until the next edge.
      applyStimulus("hold_add", 6'b000000, 6'b100000, E_ADD, 1'b0);
      @(negedge clk);
      op   = 6'b101011;
      func = 6'bxxxxxx;
      #1;
      checkOutput("no_early_update", observed(), E_ADD);
      @(posedge clk);
      #1;
      checkOutput("sw_after_edge", observed(), E_SW);

      // Reset asserted mid-stream beats a valid decode on the same edge.
      @(negedge clk);
      op   = 6'b000000;
      func = 6'b100000;
      rst  = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("midstream_reset", observed(), E_NOP);
      checkIllegal("midstream_reset", 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("add_after_reset", observed(), E_ADD);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
